segment_load_controller: RTL and testbench
==========================================

Name: segment_load_controller

Overview:
Sequences every load of a segment register (MOV/POP Sreg, far JMP/CALL, LDS-family) into the six-entry segment register file and its descriptor cache. Real mode: derives base/limit from the selector directly. Protected mode: fetches the 8-byte descriptor from GDT/LDT over a memory read handshake, runs type/present checks, then commits or reports a fault. Sits between the microcode sequencer and the segment register file/bus interface.

Parameters:
ADDR_W, 32, linear address width of descriptor fetches and base output

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  1  load request
req_ready  out  1  high only in IDLE
req_index  in  3  0=CS 1=SS 2=DS 3=ES 4=FS 5=GS
req_selector  in  16  selector to load
protected_mode  in  1  CR0.PE, sampled at accept
gdt_base  in  ADDR_W  GDTR base
gdt_limit  in  16  GDTR limit
ldt_base  in  ADDR_W  LDTR cached base
ldt_limit  in  16  LDTR cached limit (low 16 bits)
mem_req_valid  out  1  descriptor dword read request
mem_req_ready  in  1  bus accepts request
mem_addr  out  ADDR_W  dword address
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  32  read data
seg_write_enable  out  1  write strobe to segment register file
seg_write_index  out  5  zero-extended req_index
seg_write_data  out  16  selector
cache_write_enable  out  1  descriptor cache strobe
cache_index  out  3  cache entry
cache_base  out  ADDR_W  segment base
cache_limit  out  32  byte-granular limit
cache_attr  out  8  access-rights byte
done_valid  out  1  one-cycle pulse: load committed
fault_valid  out  1  one-cycle pulse: load faulted
fault_vector  out  8  11=#NP, 12=#SS, 13=#GP
fault_code  out  16  error code
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all strobes/pulses, mem_req_valid, busy 0; all data outputs 0. Reset mid-operation aborts: no write, no done/fault, mem_req_valid drops same cycle; a late mem_rsp_valid in IDLE is ignored.
- Accept on req_valid & req_ready; latch index, selector, mode, table base/limit. req_index>5 at accept -> fault #GP, code 0.
- States: IDLE -> CHECK -> {COMMIT | FETCH_LO | FAULT}; FETCH_LO -> WAIT_LO -> FETCH_HI -> WAIT_HI -> VALIDATE -> {COMMIT | FAULT}; COMMIT/FAULT -> IDLE.
- Real mode: CHECK -> COMMIT. base = selector<<4 (zero-extended), limit = 0x0000FFFF, attr = 0x9B for CS else 0x93. Committing at accept+2.
- Protected, CHECK order (first hit wins): null selector (sel[15:2]==0) with CS/SS -> #GP code 0; null with DS/ES/FS/GS -> COMMIT with base 0, limit 0, attr 0 (no fetch); (sel|7) > table limit (TI=sel[2]: 0 GDT, 1 LDT) -> #GP code sel&0xFFFC; else fetch.
- FETCH_LO: mem_addr = table_base + (sel&0xFFF8); mem_req_valid held until mem_req_ready. WAIT_LO: wait mem_rsp_valid, latch lo. FETCH_HI/WAIT_HI same at +4. Address addition wraps modulo 2^ADDR_W. One outstanding read; mem_rsp_valid outside WAIT states ignored.
- Decode: base = {hi[31:24],hi[7:0],lo[31:16]}; limit20 = {hi[19:16],lo[15:0]}; G=hi[23]: limit = G ? {limit20,12'hFFF} : zero-extended; attr = hi[15:8].
- VALIDATE order: S=0 -> #GP; CS not code (attr[3]=0) -> #GP; SS not writable data (attr[3]=1 or attr[1]=0) -> #GP; DS/ES/FS/GS execute-only code (attr[3]=1, attr[1]=0) -> #GP; P=0 -> #SS for SS, else #NP. Code = sel&0xFFFC. Privilege checks out of scope.
- COMMIT: seg_write_enable, cache_write_enable, done_valid high exactly one cycle, same cycle; data outputs valid that cycle, held until next commit. FAULT: fault_valid one cycle, no write strobes.
- req_ready falls the cycle after accept; back-to-back request accepted the cycle after COMMIT/FAULT.

Test Plan:
- Real mode, DS, sel 0x1234 -> accept+2: seg_write_index 2, data 0x1234, base 0x00012340, limit 0x0000FFFF, attr 0x93, done pulse.
- PM, SS, sel 0x0010, gdt_base 0x1000, limit 0xFF; reads 0x1010 -> 0x0000FFFF, 0x1014 -> 0x00CF9300 -> base 0, limit 0xFFFFFFFF, attr 0x93, commit.
- PM, ES, sel 0x0003 -> commit null: base 0, limit 0, attr 0, no mem_req_valid; CS sel 0x0000 -> #GP code 0.
- PM, DS, sel 0x0108 with gdt_limit 0x00FF -> #GP code 0x0108, no fetch; SS descriptor with P=0 -> #SS code = sel&0xFFFC.
- mem_req_ready low 5 cycles, mem_rsp delayed 3 cycles -> mem_req_valid/mem_addr stable, result identical to zero-wait case.
- reset asserted in WAIT_HI -> next cycle IDLE, req_ready 1, no strobes; stale mem_rsp_valid ignored.

Source files
------------

// File: rtl/segment_load_controller_if.sv
// Request handshake from the microcode sequencer and descriptor-read bus
// for the segment load controller.
interface segment_load_controller_if #(
    parameter int ADDR_W = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_index;
    logic [15:0]       req_selector;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rsp_valid;
    logic [31:0]       mem_rsp_data;

    // slave is the controller's view; master is the sequencer plus bus side
    modport slave (
        input  req_valid, req_index, req_selector,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, mem_req_valid, mem_addr
    );

    modport master (
        output req_valid, req_index, req_selector,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, mem_req_valid, mem_addr
    );
endinterface

// File: rtl/segment_load_controller.sv
// Sequences segment register loads: real-mode base derivation, or protected-mode
// descriptor fetch from GDT/LDT with type/present checks, then commit or fault.
module segment_load_controller #(
    parameter int ADDR_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    segment_load_controller_if.slave bus,
    input  logic                  protected_mode,
    input  logic [ADDR_W-1:0]     gdt_base,
    input  logic [15:0]           gdt_limit,
    input  logic [ADDR_W-1:0]     ldt_base,
    input  logic [15:0]           ldt_limit,
    output logic                  seg_write_enable,
    output logic [4:0]            seg_write_index,
    output logic [15:0]           seg_write_data,
    output logic                  cache_write_enable,
    output logic [2:0]            cache_index,
    output logic [ADDR_W-1:0]     cache_base,
    output logic [31:0]           cache_limit,
    output logic [7:0]            cache_attr,
    output logic                  done_valid,
    output logic                  fault_valid,
    output logic [7:0]            fault_vector,
    output logic [15:0]           fault_code,
    output logic                  busy
);

    typedef enum logic [3:0] {
        IDLE, CHECK, FETCH_LO, WAIT_LO, FETCH_HI, WAIT_HI, VALIDATE, COMMIT, FAULT
    } state_t;

    state_t            state_q;
    logic [2:0]        index_q;
    logic [15:0]       selector_q;
    logic              pm_q;
    logic [ADDR_W-1:0] tableBase_q;
    logic [15:0]       tableLimit_q;
    logic [31:0]       descLo_q;
    logic [31:0]       descHi_q;
    logic              reqReady_q;
    logic              busy_q;
    logic              memReqValid_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic              segWe_q;
    logic [4:0]        segIndex_q;
    logic [15:0]       segData_q;
    logic              cacheWe_q;
    logic [2:0]        cacheIndex_q;
    logic [ADDR_W-1:0] cacheBase_q;
    logic [31:0]       cacheLimit_q;
    logic [7:0]        cacheAttr_q;
    logic              done_q;
    logic              faultValid_q;
    logic [7:0]        faultVector_q;
    logic [15:0]       faultCode_q;

    logic              selNull;
    logic              overLimit;
    logic [15:0]       selCode;
    logic [ADDR_W-1:0] descAddr;
    logic [31:0]       descBase32;
    logic [19:0]       limit20;
    logic [31:0]       descLimit;
    logic [7:0]        descAttr;
    logic              unusedHiBits;

    logic              goCommit_d;
    logic              goFault_d;
    logic [7:0]        faultVec_d;
    logic [15:0]       faultCode_d;
    logic [ADDR_W-1:0] base_d;
    logic [31:0]       limit_d;
    logic [7:0]        attr_d;

    assign selNull      = (selector_q[15:2] == 14'd0);
    assign overLimit    = ({selector_q[15:3], 3'b111} > tableLimit_q);
    assign selCode      = {selector_q[15:2], 2'b00};
    assign descAddr     = tableBase_q + ADDR_W'({selector_q[15:3], 3'b000});
    assign descBase32   = {descHi_q[31:24], descHi_q[7:0], descLo_q[31:16]};
    assign limit20      = {descHi_q[19:16], descLo_q[15:0]};
    assign descLimit    = descHi_q[23] ? {limit20, 12'hFFF} : {12'h000, limit20};
    assign descAttr     = descHi_q[15:8];
    assign unusedHiBits = ^descHi_q[22:20];

    // Decide the outcome of CHECK and VALIDATE; neither commit nor fault in CHECK means fetch
    always_comb begin
        goCommit_d  = 1'b0;
        goFault_d   = 1'b0;
        faultVec_d  = 8'd13;
        faultCode_d = 16'h0000;
        base_d      = '0;
        limit_d     = 32'h0000_0000;
        attr_d      = 8'h00;
        if (state_q == CHECK) begin
            if (index_q > 3'd5) begin
                goFault_d = 1'b1;
            end else if (!pm_q) begin
                goCommit_d = 1'b1;
                base_d     = ADDR_W'({selector_q, 4'h0});
                limit_d    = 32'h0000_FFFF;
                attr_d     = (index_q == 3'd0) ? 8'h9B : 8'h93;
            end else if (selNull) begin
                if (index_q <= 3'd1) goFault_d = 1'b1;
                else                 goCommit_d = 1'b1;
            end else if (overLimit) begin
                goFault_d   = 1'b1;
                faultCode_d = selCode;
            end
        end else if (state_q == VALIDATE) begin
            faultCode_d = selCode;
            base_d      = ADDR_W'(descBase32);
            limit_d     = descLimit;
            attr_d      = descAttr;
            if (!descAttr[4]) begin
                goFault_d = 1'b1;
            end else if (index_q == 3'd0 && !descAttr[3]) begin
                goFault_d = 1'b1;
            end else if (index_q == 3'd1 && (descAttr[3] || !descAttr[1])) begin
                goFault_d = 1'b1;
            end else if (index_q > 3'd1 && descAttr[3] && !descAttr[1]) begin
                goFault_d = 1'b1;
            end else if (!descAttr[7]) begin
                goFault_d  = 1'b1;
                faultVec_d = (index_q == 3'd1) ? 8'd12 : 8'd11;
            end else begin
                goCommit_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            index_q       <= 3'd0;
            selector_q    <= 16'h0000;
            pm_q          <= 1'b0;
            tableBase_q   <= '0;
            tableLimit_q  <= 16'h0000;
            descLo_q      <= 32'h0;
            descHi_q      <= 32'h0;
            reqReady_q    <= 1'b1;
            busy_q        <= 1'b0;
            memReqValid_q <= 1'b0;
            memAddr_q     <= '0;
            segWe_q       <= 1'b0;
            segIndex_q    <= 5'd0;
            segData_q     <= 16'h0000;
            cacheWe_q     <= 1'b0;
            cacheIndex_q  <= 3'd0;
            cacheBase_q   <= '0;
            cacheLimit_q  <= 32'h0;
            cacheAttr_q   <= 8'h00;
            done_q        <= 1'b0;
            faultValid_q  <= 1'b0;
            faultVector_q <= 8'h00;
            faultCode_q   <= 16'h0000;
        end else begin
            segWe_q      <= 1'b0;
            cacheWe_q    <= 1'b0;
            done_q       <= 1'b0;
            faultValid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        index_q      <= bus.req_index;
                        selector_q   <= bus.req_selector;
                        pm_q         <= protected_mode;
                        tableBase_q  <= bus.req_selector[2] ? ldt_base : gdt_base;
                        tableLimit_q <= bus.req_selector[2] ? ldt_limit : gdt_limit;
                        reqReady_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= CHECK;
                    end
                end
                CHECK, VALIDATE: begin
                    if (goCommit_d) begin
                        segWe_q      <= 1'b1;
                        cacheWe_q    <= 1'b1;
                        done_q       <= 1'b1;
                        segIndex_q   <= {2'b00, index_q};
                        segData_q    <= selector_q;
                        cacheIndex_q <= index_q;
                        cacheBase_q  <= base_d;
                        cacheLimit_q <= limit_d;
                        cacheAttr_q  <= attr_d;
                        state_q      <= COMMIT;
                    end else if (goFault_d) begin
                        faultValid_q  <= 1'b1;
                        faultVector_q <= faultVec_d;
                        faultCode_q   <= faultCode_d;
                        state_q       <= FAULT;
                    end else begin
                        memReqValid_q <= 1'b1;
                        memAddr_q     <= descAddr;
                        state_q       <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (bus.mem_req_ready) begin
                        memReqValid_q <= 1'b0;
                        state_q       <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (bus.mem_rsp_valid) begin
                        descLo_q      <= bus.mem_rsp_data;
                        memReqValid_q <= 1'b1;
                        memAddr_q     <= memAddr_q + ADDR_W'(4);
                        state_q       <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_req_ready) begin
                        memReqValid_q <= 1'b0;
                        state_q       <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (bus.mem_rsp_valid) begin
                        descHi_q <= bus.mem_rsp_data;
                        state_q  <= VALIDATE;
                    end
                end
                COMMIT, FAULT: begin
                    reqReady_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    reqReady_q    <= 1'b1;
                    busy_q        <= 1'b0;
                    memReqValid_q <= 1'b0;
                    state_q       <= IDLE;
                end
            endcase
        end
    end

    // Request strobe is gated by reset so an aborted fetch disappears immediately
    assign bus.mem_req_valid = memReqValid_q & ~reset;
    assign bus.mem_addr      = memAddr_q;
    assign bus.req_ready     = reqReady_q;

    assign seg_write_enable   = segWe_q;
    assign seg_write_index    = segIndex_q;
    assign seg_write_data     = segData_q;
    assign cache_write_enable = cacheWe_q;
    assign cache_index        = cacheIndex_q;
    assign cache_base         = cacheBase_q;
    assign cache_limit        = cacheLimit_q;
    assign cache_attr         = cacheAttr_q;
    assign done_valid         = done_q;
    assign fault_valid        = faultValid_q;
    assign fault_vector       = faultVector_q;
    assign fault_code         = faultCode_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_segment_load_controller.sv
// Directed bench for segment_load_controller: expected commits/faults are queued
// when a request is issued and matched against done/fault pulses by a monitor.
module tb_segment_load_controller;

    logic        clock;
    logic        reset;
    logic        protected_mode;
    logic [31:0] gdt_base;
    logic [15:0] gdt_limit;
    logic [31:0] ldt_base;
    logic [15:0] ldt_limit;
    logic        seg_write_enable;
    logic [4:0]  seg_write_index;
    logic [15:0] seg_write_data;
    logic        cache_write_enable;
    logic [2:0]  cache_index;
    logic [31:0] cache_base;
    logic [31:0] cache_limit;
    logic [7:0]  cache_attr;
    logic        done_valid;
    logic        fault_valid;
    logic [7:0]  fault_vector;
    logic [15:0] fault_code;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    typedef struct {
        string       tag;
        bit          isFault;
        logic [2:0]  idx;
        logic [15:0] sel;
        logic [31:0] base;
        logic [31:0] limit;
        logic [7:0]  attr;
        logic [7:0]  vec;
        logic [15:0] code;
    } expT;

    expT sb[$];

    segment_load_controller_if #(.ADDR_W(32)) bus ();

    segment_load_controller #(.ADDR_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus),
        .protected_mode     (protected_mode),
        .gdt_base           (gdt_base),
        .gdt_limit          (gdt_limit),
        .ldt_base           (ldt_base),
        .ldt_limit          (ldt_limit),
        .seg_write_enable   (seg_write_enable),
        .seg_write_index    (seg_write_index),
        .seg_write_data     (seg_write_data),
        .cache_write_enable (cache_write_enable),
        .cache_index        (cache_index),
        .cache_base         (cache_base),
        .cache_limit        (cache_limit),
        .cache_attr         (cache_attr),
        .done_valid         (done_valid),
        .fault_valid        (fault_valid),
        .fault_vector       (fault_vector),
        .fault_code         (fault_code),
        .busy               (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic void pushCommit(input string tag, input logic [2:0] idx, input logic [15:0] sel,
                                       input logic [31:0] base, input logic [31:0] limit, input logic [7:0] attr);
        expT e;
        e.tag = tag; e.isFault = 1'b0; e.idx = idx; e.sel = sel;
        e.base = base; e.limit = limit; e.attr = attr; e.vec = 8'h00; e.code = 16'h0000;
        sb.push_back(e);
    endfunction

    function automatic void pushFault(input string tag, input logic [7:0] vec, input logic [15:0] code);
        expT e;
        e.tag = tag; e.isFault = 1'b1; e.idx = 3'd0; e.sel = 16'h0000;
        e.base = 32'h0; e.limit = 32'h0; e.attr = 8'h00; e.vec = vec; e.code = code;
        sb.push_back(e);
    endfunction

    // Present a request at a falling edge and return once it has been accepted
    task automatic applyStimulus(input logic [2:0] idx, input logic [15:0] sel, input logic pm);
        int n;
        bus.req_index    = idx;
        bus.req_selector = sel;
        protected_mode   = pm;
        bus.req_valid    = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput("reqReadyAtAccept", 32'(bus.req_ready), 32'h1);
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    task automatic acceptRead(input string tag, input logic [31:0] expAddr, input int readyDelay);
        int n;
        n = 0;
        while (bus.mem_req_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "/memReqValid"}, 32'(bus.mem_req_valid), 32'h1);
        checkOutput({tag, "/memAddr"}, bus.mem_addr, expAddr);
        for (int i = 0; i < readyDelay; i++) begin
            @(negedge clock);
            checkOutput({tag, "/stallValid"}, 32'(bus.mem_req_valid), 32'h1);
            checkOutput({tag, "/stallAddr"}, bus.mem_addr, expAddr);
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clock);
        bus.mem_req_ready = 1'b0;
        checkOutput({tag, "/memReqDropped"}, 32'(bus.mem_req_valid), 32'h0);
    endtask

    task automatic sendResponse(input int rspDelay, input logic [31:0] data);
        repeat (rspDelay) @(negedge clock);
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = data;
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
    endtask

    task automatic waitIdle(input string tag, output bit sawMem);
        int n;
        n = 0;
        sawMem = 1'b0;
        while (busy === 1'b1 && n < 100) begin
            if (bus.mem_req_valid === 1'b1) sawMem = 1'b1;
            @(negedge clock);
            n++;
        end
        checkOutput({tag, "/idle"}, 32'(busy), 32'h0);
    endtask

    // Scoreboard monitor: every done/fault pulse must match the oldest queued expectation
    initial begin
        expT e;
        forever begin
            @(negedge clock);
            if (reset === 1'b0 && (done_valid === 1'b1 || fault_valid === 1'b1)) begin
                assertCount++;
                assert (sb.size() > 0) else begin
                    failCount++;
                    $error("[TB] FAIL unexpectedPulse observed=%0d expected=0 (done=%b fault=%b)",
                           1, done_valid, fault_valid);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    if (e.isFault) begin
                        checkOutput({e.tag, "/faultValid"}, 32'(fault_valid), 32'h1);
                        checkOutput({e.tag, "/noSegWrite"}, 32'(seg_write_enable), 32'h0);
                        checkOutput({e.tag, "/noCacheWrite"}, 32'(cache_write_enable), 32'h0);
                        checkOutput({e.tag, "/faultVector"}, 32'(fault_vector), 32'(e.vec));
                        checkOutput({e.tag, "/faultCode"}, 32'(fault_code), 32'(e.code));
                    end else begin
                        checkOutput({e.tag, "/doneValid"}, 32'(done_valid), 32'h1);
                        checkOutput({e.tag, "/noFault"}, 32'(fault_valid), 32'h0);
                        checkOutput({e.tag, "/segWe"}, 32'(seg_write_enable), 32'h1);
                        checkOutput({e.tag, "/cacheWe"}, 32'(cache_write_enable), 32'h1);
                        checkOutput({e.tag, "/segIndex"}, 32'(seg_write_index), 32'(e.idx));
                        checkOutput({e.tag, "/segData"}, 32'(seg_write_data), 32'(e.sel));
                        checkOutput({e.tag, "/cacheIndex"}, 32'(cache_index), 32'(e.idx));
                        checkOutput({e.tag, "/base"}, cache_base, e.base);
                        checkOutput({e.tag, "/limit"}, cache_limit, e.limit);
                        checkOutput({e.tag, "/attr"}, 32'(cache_attr), 32'(e.attr));
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit sawMem;
        reset             = 1'b1;
        protected_mode    = 1'b0;
        gdt_base          = 32'h0000_1000;
        gdt_limit         = 16'h00FF;
        ldt_base          = 32'h0000_2000;
        ldt_limit         = 16'h000F;
        bus.req_valid     = 1'b0;
        bus.req_index     = 3'd0;
        bus.req_selector  = 16'h0000;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        repeat (3) @(negedge clock);

        checkOutput("rst/reqReady", 32'(bus.req_ready), 32'h1);
        checkOutput("rst/busy", 32'(busy), 32'h0);
        checkOutput("rst/memReqValid", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("rst/strobes", 32'({seg_write_enable, cache_write_enable, done_valid, fault_valid}), 32'h0);
        checkOutput("rst/cacheBase", cache_base, 32'h0);
        checkOutput("rst/faultVector", 32'(fault_vector), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Real mode: commit two cycles after accept, then ready again the next cycle
        pushCommit("realDS", 3'd2, 16'h1234, 32'h0001_2340, 32'h0000_FFFF, 8'h93);
        applyStimulus(3'd2, 16'h1234, 1'b0);
        checkOutput("realDS/reqReadyLow", 32'(bus.req_ready), 32'h0);
        checkOutput("realDS/busy", 32'(busy), 32'h1);
        checkOutput("realDS/noEarlyDone", 32'(done_valid), 32'h0);
        @(negedge clock);
        checkOutput("realDS/doneAtAccept2", 32'(done_valid), 32'h1);
        @(negedge clock);
        checkOutput("realDS/readyAfterCommit", 32'(bus.req_ready), 32'h1);
        checkOutput("realDS/donePulseOnce", 32'(done_valid), 32'h0);
        checkOutput("realDS/baseHeld", cache_base, 32'h0001_2340);

        pushCommit("realCS", 3'd0, 16'hF000, 32'h000F_0000, 32'h0000_FFFF, 8'h9B);
        applyStimulus(3'd0, 16'hF000, 1'b0);
        waitIdle("realCS", sawMem);

        pushFault("badIndex", 8'd13, 16'h0000);
        applyStimulus(3'd6, 16'h1234, 1'b0);
        waitIdle("badIndex", sawMem);

        // Protected mode, zero-wait descriptor fetch
        pushCommit("pmSS", 3'd1, 16'h0010, 32'h0000_0000, 32'hFFFF_FFFF, 8'h93);
        applyStimulus(3'd1, 16'h0010, 1'b1);
        acceptRead("pmSS/lo", 32'h0000_1010, 0);
        sendResponse(0, 32'h0000_FFFF);
        acceptRead("pmSS/hi", 32'h0000_1014, 0);
        sendResponse(0, 32'h00CF_9300);
        waitIdle("pmSS", sawMem);

        // Same load with a stalled bus must give the identical result
        pushCommit("pmSSstall", 3'd1, 16'h0010, 32'h0000_0000, 32'hFFFF_FFFF, 8'h93);
        applyStimulus(3'd1, 16'h0010, 1'b1);
        acceptRead("pmSSstall/lo", 32'h0000_1010, 5);
        sendResponse(3, 32'h0000_FFFF);
        acceptRead("pmSSstall/hi", 32'h0000_1014, 5);
        sendResponse(3, 32'h00CF_9300);
        waitIdle("pmSSstall", sawMem);

        pushCommit("nullES", 3'd3, 16'h0003, 32'h0, 32'h0, 8'h00);
        applyStimulus(3'd3, 16'h0003, 1'b1);
        waitIdle("nullES", sawMem);
        checkOutput("nullES/noFetch", 32'(sawMem), 32'h0);

        pushFault("nullCS", 8'd13, 16'h0000);
        applyStimulus(3'd0, 16'h0000, 1'b1);
        waitIdle("nullCS", sawMem);

        pushFault("limitDS", 8'd13, 16'h0108);
        applyStimulus(3'd2, 16'h0108, 1'b1);
        waitIdle("limitDS", sawMem);
        checkOutput("limitDS/noFetch", 32'(sawMem), 32'h0);

        pushFault("ssNotPresent", 8'd12, 16'h0018);
        applyStimulus(3'd1, 16'h0018, 1'b1);
        acceptRead("ssNotPresent/lo", 32'h0000_1018, 0);
        sendResponse(0, 32'h0000_FFFF);
        acceptRead("ssNotPresent/hi", 32'h0000_101C, 0);
        sendResponse(0, 32'h00CF_1300);
        waitIdle("ssNotPresent", sawMem);

        pushFault("dsNotPresent", 8'd11, 16'h0020);
        applyStimulus(3'd2, 16'h0021, 1'b1);
        acceptRead("dsNotPresent/lo", 32'h0000_1020, 0);
        sendResponse(0, 32'h0000_FFFF);
        acceptRead("dsNotPresent/hi", 32'h0000_1024, 1);
        sendResponse(1, 32'h00CF_1300);
        waitIdle("dsNotPresent", sawMem);

        pushFault("csDataDesc", 8'd13, 16'h0008);
        applyStimulus(3'd0, 16'h0008, 1'b1);
        acceptRead("csDataDesc/lo", 32'h0000_1008, 0);
        sendResponse(0, 32'h0000_FFFF);
        acceptRead("csDataDesc/hi", 32'h0000_100C, 0);
        sendResponse(0, 32'h00CF_9300);
        waitIdle("csDataDesc", sawMem);

        // LDT-relative selector with a byte-granular readable code descriptor
        pushCommit("ldtDS", 3'd2, 16'h000C, 32'h1234_5678, 32'h0000_FFFF, 8'h9A);
        applyStimulus(3'd2, 16'h000C, 1'b1);
        acceptRead("ldtDS/lo", 32'h0000_2008, 0);
        sendResponse(0, 32'h5678_FFFF);
        acceptRead("ldtDS/hi", 32'h0000_200C, 0);
        sendResponse(0, 32'h1240_9A34);
        waitIdle("ldtDS", sawMem);

        // Reset while waiting for the high dword aborts the load silently
        applyStimulus(3'd2, 16'h0010, 1'b1);
        acceptRead("abort/lo", 32'h0000_1010, 0);
        sendResponse(0, 32'h0000_FFFF);
        acceptRead("abort/hi", 32'h0000_1014, 0);
        checkOutput("abort/inWaitHi", 32'(busy), 32'h1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort/reqReady", 32'(bus.req_ready), 32'h1);
        checkOutput("abort/busy", 32'(busy), 32'h0);
        checkOutput("abort/strobes", 32'({seg_write_enable, cache_write_enable, done_valid, fault_valid}), 32'h0);
        checkOutput("abort/memReqValid", 32'(bus.mem_req_valid), 32'h0);
        checkOutput("abort/cacheLimitCleared", cache_limit, 32'h0);
        reset = 1'b0;
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = 32'h00CF_9300;
        @(negedge clock);
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = 32'h0;
        repeat (2) @(negedge clock);
        checkOutput("staleRsp/busy", 32'(busy), 32'h0);
        checkOutput("staleRsp/reqReady", 32'(bus.req_ready), 32'h1);
        checkOutput("staleRsp/noDone", 32'(done_valid), 32'h0);

        pushCommit("recoverES", 3'd3, 16'hB800, 32'h000B_8000, 32'h0000_FFFF, 8'h93);
        applyStimulus(3'd3, 16'hB800, 1'b0);
        waitIdle("recoverES", sawMem);

        repeat (3) @(negedge clock);
        checkOutput("scoreboardDrained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
